// File: rtl/mem_arb_pkg.sv
// Shared widths and FSM state encoding for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the memory-hierarchy port.
// slave is the arbiter's view, master is the surrounding system's view.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              p0_request;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_din;
    logic              p0_ready;
    logic [DATA_W-1:0] p0_dout;

    logic              p1_request;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_din;
    logic              p1_ready;
    logic [DATA_W-1:0] p1_dout;

    logic              d_request;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_din;
    logic              d_ready;
    logic [DATA_W-1:0] d_dout;

    modport slave (
        input  p0_request, p0_we, p0_addr, p0_din,
        input  p1_request, p1_we, p1_addr, p1_din,
        input  d_ready, d_dout,
        output p0_ready, p0_dout, p1_ready, p1_dout,
        output d_request, d_we, d_addr, d_din
    );

    modport master (
        output p0_request, p0_we, p0_addr, p0_din,
        output p1_request, p1_we, p1_addr, p1_din,
        output d_ready, d_dout,
        input  p0_ready, p0_dout, p1_ready, p1_dout,
        input  d_request, d_we, d_addr, d_din
    );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of the memory hierarchy port.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transaction; grant the next requester and latch its fields
// ISSUE | d_request high with latched fields, waiting for d_ready
// RESP  | pulse the granted port's ready, d_request low
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    state_t            state;
    state_t            state_nxt;
    logic              any_req;
    logic              pick;
    logic              grant_port;
    logic              last_grant;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic [DATA_W-1:0] dout0_q;
    logic [DATA_W-1:0] dout1_q;

    // Round-robin pick: on a tie the port not granted last wins.
    always_comb begin
        any_req = bus.p0_request | bus.p1_request;
        pick    = 1'b0;
        if (bus.p0_request && bus.p1_request) begin
            pick = ~last_grant;
        end else if (bus.p1_request) begin
            pick = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; d_ready only matters while in ISSUE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   if (bus.d_ready) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant bookkeeping, latched request fields and per-port read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_port <= 1'b0;
            last_grant <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            dout0_q    <= '0;
            dout1_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_port <= pick;
                        last_grant <= pick;
                        we_q       <= pick ? bus.p1_we   : bus.p0_we;
                        addr_q     <= pick ? bus.p1_addr : bus.p0_addr;
                        din_q      <= pick ? bus.p1_din  : bus.p0_din;
                    end
                end
                ISSUE: begin
                    if (bus.d_ready) begin
                        if (grant_port) begin
                            dout1_q <= bus.d_dout;
                        end else begin
                            dout0_q <= bus.d_dout;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.d_request = (state == ISSUE);
    assign bus.d_we      = we_q;
    assign bus.d_addr    = addr_q;
    assign bus.d_din     = din_q;
    assign bus.p0_ready  = (state == RESP) && !grant_port;
    assign bus.p1_ready  = (state == RESP) && grant_port;
    assign bus.p0_dout   = dout0_q;
    assign bus.p1_dout   = dout1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a transaction-level
// memory/arbitration reference model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] din;
    } txn_t;

    typedef struct {
        int         port;
        logic [7:0] dout;
    } resp_t;

    logic clk;
    logic rst;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total;
    int bad;

    txn_t  issue_q[$];
    resp_t resp_q[$];

    logic [7:0] ref_mem  [256];
    logic [7:0] hier_mem [256];
    int         last_g;
    int         lat_force;
    logic       spur;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Service-order reference: one transaction applied to the model memory.
    function automatic void model_txn(int p, txn_t t);
        resp_t r;
        issue_q.push_back(t);
        r.port = p;
        r.dout = ref_mem[t.addr];
        resp_q.push_back(r);
        if (t.we) ref_mem[t.addr] = t.din;
        last_g = p;
    endfunction

    function automatic txn_t rnd_txn();
        txn_t t;
        t.we   = 1'($urandom_range(0, 1));
        t.addr = 8'($urandom_range(0, 15));
        t.din  = 8'($urandom);
        return t;
    endfunction

    function automatic logic port_ready(int p);
        return (p == 0) ? bus.p0_ready : bus.p1_ready;
    endfunction

    task automatic set_port(int p, logic req, txn_t t);
        if (p == 0) begin
            bus.p0_request = req; bus.p0_we = t.we; bus.p0_addr = t.addr; bus.p0_din = t.din;
        end else begin
            bus.p1_request = req; bus.p1_we = t.we; bus.p1_addr = t.addr; bus.p1_din = t.din;
        end
    endtask

    // One requester transaction: raise, wait for ready, drop for one cycle.
    task automatic do_port(int p, txn_t t);
        int n;
        n = 0;
        set_port(p, 1'b1, t);
        while (n < 300) begin
            @(negedge clk);
            if (port_ready(p)) break;
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL port%0d_timeout got=no_ready want=ready", p);
        end
        @(posedge clk);
        #1 set_port(p, 1'b0, t);
        @(posedge clk);
        #1;
    endtask

    // Memory hierarchy model: random (or forced) latency, read-before-write data.
    initial begin
        int cnt;
        cnt = -1;
        bus.d_ready = 1'b0;
        bus.d_dout  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                bus.d_ready = 1'b0;
                cnt = -1;
            end else if (bus.d_ready) begin
                bus.d_ready = 1'b0;
            end else if (spur) begin
                bus.d_ready = 1'b1;
                bus.d_dout  = 8'hEE;
                spur = 1'b0;
            end else if (bus.d_request && lat_force != -2) begin
                if (cnt < 0) cnt = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 3));
                if (cnt == 0) begin
                    bus.d_dout = hier_mem[bus.d_addr];
                    if (bus.d_we) hier_mem[bus.d_addr] = bus.d_din;
                    bus.d_ready = 1'b1;
                    cnt = -1;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT issues or completes.
    initial begin
        logic       prev_dreq;
        logic [1:0] prev_rdy;
        int         low_cnt;
        txn_t       cur;
        txn_t       e;
        resp_t      r;
        logic [7:0] exp_dout [2];
        prev_dreq = 1'b0;
        prev_rdy  = 2'b00;
        low_cnt   = 2;
        exp_dout[0] = 8'h00;
        exp_dout[1] = 8'h00;
        cur = '{we: 1'b0, addr: 8'h00, din: 8'h00};
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_dreq = 1'b0;
                prev_rdy  = 2'b00;
                low_cnt   = 2;
                exp_dout[0] = 8'h00;
                exp_dout[1] = 8'h00;
                continue;
            end
            if (bus.d_request && !prev_dreq) begin
                chk("dreq_gap_ge2", int'(low_cnt >= 2), 1);
                if (issue_q.size() == 0) begin
                    chk("issue_unexpected", 1, 0);
                end else begin
                    e = issue_q.pop_front();
                    cur = e;
                    chk("issue_we", int'(bus.d_we), int'(e.we));
                    chk("issue_addr", int'(bus.d_addr), int'(e.addr));
                    chk("issue_din", int'(bus.d_din), int'(e.din));
                end
            end else if (bus.d_request) begin
                chk("hold_fields", int'({bus.d_we, bus.d_addr, bus.d_din}),
                    int'({cur.we, cur.addr, cur.din}));
            end
            low_cnt   = bus.d_request ? 0 : low_cnt + 1;
            prev_dreq = bus.d_request;

            if (bus.p0_ready && bus.p1_ready) chk("both_ready", 1, 0);
            for (int p = 0; p < 2; p++) begin
                logic [7:0] dv;
                dv = (p == 0) ? bus.p0_dout : bus.p1_dout;
                if (port_ready(p)) begin
                    if (prev_rdy[p]) chk("ready_width", 2, 1);
                    if (resp_q.size() == 0) begin
                        chk("ready_unexpected", p, -1);
                    end else begin
                        r = resp_q.pop_front();
                        chk("resp_port", p, r.port);
                        chk("resp_dout", int'(dv), int'(r.dout));
                        exp_dout[p] = r.dout;
                    end
                end else begin
                    chk("dout_hold", int'(dv), int'(exp_dout[p]));
                end
                prev_rdy[p] = port_ready(p);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t a0 [4];
        txn_t a1 [4];
        txn_t t;
        txn_t u;
        int   first;
        int   n;
        int   kind;

        rst = 1'b1;
        spur = 1'b0;
        lat_force = -1;
        last_g = 1;
        t = '{we: 1'b0, addr: 8'h00, din: 8'h00};
        set_port(0, 1'b0, t);
        set_port(1, 1'b0, t);
        for (int i = 0; i < 256; i++) begin
            ref_mem[i]  = 8'($urandom);
            hier_mem[i] = ref_mem[i];
        end
        repeat (3) @(negedge clk);
        chk("rst_dreq", int'(bus.d_request), 0);
        chk("rst_fields", int'({bus.d_we, bus.d_addr, bus.d_din}), 0);
        chk("rst_ready", int'({bus.p0_ready, bus.p1_ready}), 0);
        chk("rst_dout", int'({bus.p0_dout, bus.p1_dout}), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single read with a 4-cycle hierarchy response.
        lat_force = 4;
        ref_mem[8'h12] = 8'h5A;
        hier_mem[8'h12] = 8'h5A;
        t = '{we: 1'b0, addr: 8'h12, din: 8'h00};
        model_txn(0, t);
        do_port(0, t);
        chk("single_read_dout", int'(bus.p0_dout), 8'h5A);
        lat_force = -1;

        // Fresh reset, then simultaneous first requests: p0 write, p1 read back.
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        last_g = 1;
        t = '{we: 1'b1, addr: 8'h20, din: 8'h34};
        u = '{we: 1'b0, addr: 8'h20, din: 8'h00};
        model_txn(0, t);
        model_txn(1, u);
        fork
            do_port(0, t);
            do_port(1, u);
        join
        chk("tie_read_back", int'(bus.p1_dout), 8'h34);

        // Sustained contention: eight transactions alternate between ports.
        for (int i = 0; i < 4; i++) begin
            a0[i] = rnd_txn();
            a1[i] = rnd_txn();
        end
        first = (last_g == 1) ? 0 : 1;
        for (int i = 0; i < 4; i++) begin
            model_txn(first, (first == 0) ? a0[i] : a1[i]);
            model_txn(1 - first, (first == 0) ? a1[i] : a0[i]);
        end
        fork
            begin for (int i = 0; i < 4; i++) do_port(0, a0[i]); end
            begin for (int i = 0; i < 4; i++) do_port(1, a1[i]); end
        join

        // Late arrival while p0 is in ISSUE.
        lat_force = 3;
        t = rnd_txn();
        u = rnd_txn();
        model_txn(0, t);
        model_txn(1, u);
        fork
            do_port(0, t);
            begin
                n = 0;
                while (!bus.d_request && n < 50) begin @(negedge clk); n++; end
                chk("late_saw_issue", int'(bus.d_request), 1);
                do_port(1, u);
            end
        join
        lat_force = -1;

        // Spurious d_ready in IDLE.
        repeat (2) @(negedge clk);
        spur = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("spur_no_dreq", int'(bus.d_request), 0);
            chk("spur_no_ready", int'({bus.p0_ready, bus.p1_ready}), 0);
        end

        // Reset while in ISSUE with a stalled hierarchy.
        lat_force = -2;
        t = '{we: 1'b1, addr: 8'h5C, din: 8'hA7};
        issue_q.push_back(t);
        set_port(0, 1'b1, t);
        n = 0;
        while (!bus.d_request && n < 20) begin @(negedge clk); n++; end
        chk("rst_issue_reached", int'(bus.d_request), 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_dreq", int'(bus.d_request), 0);
        chk("midrst_fields", int'({bus.d_we, bus.d_addr, bus.d_din}), 0);
        chk("midrst_ready", int'({bus.p0_ready, bus.p1_ready}), 0);
        chk("midrst_dout", int'({bus.p0_dout, bus.p1_dout}), 0);
        set_port(0, 1'b0, t);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lat_force = -1;
        last_g = 1;
        t = rnd_txn();
        u = rnd_txn();
        model_txn(0, t);
        model_txn(1, u);
        fork
            do_port(0, t);
            do_port(1, u);
        join

        // Random batches: single, simultaneous, late arrival.
        for (int b = 0; b < 24; b++) begin
            kind = int'($urandom_range(0, 2));
            t = rnd_txn();
            u = rnd_txn();
            first = int'($urandom_range(0, 1));
            if (kind == 0) begin
                model_txn(first, t);
                do_port(first, t);
            end else if (kind == 1) begin
                first = (last_g == 1) ? 0 : 1;
                model_txn(first, t);
                model_txn(1 - first, u);
                fork
                    do_port(first, t);
                    do_port(1 - first, u);
                join
            end else begin
                model_txn(first, t);
                model_txn(1 - first, u);
                fork
                    do_port(first, t);
                    begin
                        n = 0;
                        while (!bus.d_request && n < 50) begin @(negedge clk); n++; end
                        do_port(1 - first, u);
                    end
                join
            end
        end

        repeat (3) @(negedge clk);
        chk("issue_q_drained", issue_q.size(), 0);
        chk("resp_q_drained", resp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
